// File: rtl/bc_clr_en_skid_buf.sv
// Two-entry valid/ready skid buffer with synchronous clear and global enable.
// Optional occupancy/transfer statistics outputs are built when BC_SKID_BUF_STAT_EN is defined.
module bc_clr_en_skid_buf #(
   parameter int unsigned          WIDTH    = 32,
   parameter logic [WIDTH-1:0]     INI_DATA = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             iEn,
   input  logic             iClr,
   input  logic             iVld,
   input  logic [WIDTH-1:0] iDat,
   output logic             oRdy,
   output logic             oVld,
   output logic [WIDTH-1:0] oDat,
   input  logic             iRdy
`ifdef BC_SKID_BUF_STAT_EN
   ,
   output logic [1:0]       oLvl,
   output logic [15:0]      oXferCnt
`endif
);

   // Handshake contract: a beat moves on a port only in a cycle where both
   // valid and ready are high at the clock edge; valid/ready here come from
   // registered state and iEn only, so neither output sees iVld or iRdy.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } stateT;

   stateT            state, stateNxt;
   logic [WIDTH-1:0] mainQ, mainNxt;
   logic [WIDTH-1:0] skidQ, skidNxt;
   logic             inXfer, outXfer;

   assign oVld    = iEn & (state != EMPTY);
   assign oRdy    = iEn & (state != FULL);
   assign oDat    = mainQ;
   assign inXfer  = iVld & oRdy;
   assign outXfer = oVld & iRdy;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= EMPTY;
         mainQ <= INI_DATA;
         skidQ <= INI_DATA;
      end else begin
         state <= stateNxt;
         mainQ <= mainNxt;
         skidQ <= skidNxt;
      end
   end

   always_comb begin
      stateNxt = state;
      mainNxt  = mainQ;
      skidNxt  = skidQ;
      if (iClr) begin
         // Flush wins over any handshake completing in this cycle.
         stateNxt = EMPTY;
         mainNxt  = INI_DATA;
         skidNxt  = INI_DATA;
      end else if (iEn) begin
         case (state)
            EMPTY: begin
               if (inXfer) begin
                  stateNxt = BUSY;
                  mainNxt  = iDat;
               end
            end
            BUSY: begin
               if (inXfer && outXfer) begin
                  mainNxt = iDat;
               end else if (inXfer) begin
                  stateNxt = FULL;
                  skidNxt  = iDat;
               end else if (outXfer) begin
                  stateNxt = EMPTY;
               end
            end
            FULL: begin
               if (outXfer) begin
                  stateNxt = BUSY;
                  mainNxt  = skidQ;
               end
            end
            default: begin
               stateNxt = EMPTY;
            end
         endcase
      end
   end

`ifdef BC_SKID_BUF_STAT_EN
   logic [15:0] xferCnt;

   always_ff @(posedge clk) begin
      if (rst || iClr) begin
         xferCnt <= 16'd0;
      end else if (outXfer) begin
         xferCnt <= xferCnt + 16'd1;
      end
   end

   assign oXferCnt = xferCnt;
   assign oLvl     = (state == FULL) ? 2'd2 : ((state == BUSY) ? 2'd1 : 2'd0);
`endif

endmodule
